// File: rtl/fixed_activation_arbiter_pkg.sv
// Shared types and helpers for fixed_activation_arbiter: FSM state encoding,
// width helper and the round-robin search used to pick the next tensor owner.
package fixed_activation_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Widest requester vector the round-robin helper can search.
  localparam int unsigned MAX_REQ = 32;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // First set bit of valid at or after ptr, wrapping at num; returns ptr when none is set.
  function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned num);
    int unsigned pick;
    int unsigned idx;
    logic found;
    logic [MAX_REQ-1:0] sh;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= num) begin
        idx = idx - num;
      end else begin
        idx = idx;
      end
      sh = valid >> idx;
      if (!found && (i < num) && sh[0]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arbiter_tag_fifo.sv
// In-order FIFO of owner tags for beats in flight inside the shared unit.
// A push while full is dropped even when a pop happens in the same cycle.
module arbiter_tag_fifo
  import fixed_activation_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = width_of(DEPTH);
  localparam int CNT_W = width_of(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + 1'b1;
  endfunction

  // Occupancy flags, qualified handshakes and the head tag.
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == {CNT_W{1'b0}});
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    head      = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fixed_activation_arbiter_checker.sv
// Protocol checks for fixed_activation_arbiter: a result beat from the shared
// unit must always have an outstanding owner tag.
module fixed_activation_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic act_out_valid,
  input logic tag_empty
);

  property p_no_orphan_result;
    @(posedge clk) disable iff (rst) !(act_out_valid && tag_empty);
  endproperty

  a_no_orphan_result: assert property (p_no_orphan_result);

endmodule

// File: rtl/fixed_activation_arbiter.sv
// Round-robin, whole-tensor arbiter sharing one activation unit among NUM_REQ streams.
// Optional perf counters are enabled with `define FIXED_ACTIVATION_ARBITER_PERF_EN.
module fixed_activation_arbiter
  import fixed_activation_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int PARALLELISM  = 1,
  parameter int TENSOR_BEATS = 10,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0]         act_in_data,
  output logic                                      act_in_valid,
  input  logic                                      act_in_ready,
  input  logic [PARALLELISM*DATA_WIDTH-1:0]         act_out_data,
  input  logic                                      act_out_valid,
  output logic                                      act_out_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0]         resp_data,
  output logic [NUM_REQ-1:0]                        resp_valid,
  input  logic [NUM_REQ-1:0]                        resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                grant_id,
  output logic                                      busy
`ifdef FIXED_ACTIVATION_ARBITER_PERF_EN
  ,
  output logic [31:0]                               perf_busy_cycles,
  output logic [31:0]                               perf_stall_cycles
`endif
);

  localparam int TAG_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = PARALLELISM * DATA_WIDTH;
  localparam int CNT_W  = width_of(TENSOR_BEATS);

  arb_state_e         state_r, state_s;
  logic [TAG_W-1:0]   grant_r, grant_s;
  logic [TAG_W-1:0]   rr_r, rr_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [MAX_REQ-1:0] valid_ext_s;
  logic               accept_s;
  logic               pop_s;
  logic               tag_full_s;
  logic               tag_empty_s;
  logic [TAG_W-1:0]   tag_head_s;

  // Zero-extend requests to the width the round-robin helper searches.
  always_comb begin
    valid_ext_s              = {MAX_REQ{1'b0}};
    valid_ext_s[NUM_REQ-1:0] = req_valid;
  end

  // Grant selection, forward path and burst bookkeeping.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    rr_s         = rr_r;
    cnt_s        = cnt_r;
    req_ready    = {NUM_REQ{1'b0}};
    act_in_valid = 1'b0;
    accept_s     = 1'b0;
    act_in_data  = req_data[grant_r*BEAT_W +: BEAT_W];
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          grant_s = TAG_W'(rr_next(valid_ext_s, 32'(rr_r), NUM_REQ));
          state_s = LOCKED;
        end else begin
          state_s = IDLE;
        end
      end
      LOCKED: begin
        // The owner keeps the unit until its whole tensor is through, valid or not.
        act_in_valid       = req_valid[grant_r] && !tag_full_s;
        req_ready[grant_r] = act_in_ready && !tag_full_s;
        accept_s           = act_in_valid && act_in_ready;
        if (accept_s && (cnt_r == CNT_W'(TENSOR_BEATS - 1))) begin
          cnt_s   = {CNT_W{1'b0}};
          rr_s    = (grant_r == TAG_W'(NUM_REQ - 1)) ? {TAG_W{1'b0}} : grant_r + 1'b1;
          state_s = IDLE;
        end else if (accept_s) begin
          cnt_s = cnt_r + 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Return path steered by the oldest outstanding tag.
  always_comb begin
    resp_valid    = {NUM_REQ{1'b0}};
    act_out_ready = 1'b0;
    if (!tag_empty_s) begin
      resp_valid[tag_head_s] = act_out_valid;
      act_out_ready          = resp_ready[tag_head_s];
    end else begin
      act_out_ready = 1'b0;
    end
    pop_s     = act_out_valid && act_out_ready;
    resp_data = act_out_data;
  end

  // FSM, owner, round-robin pointer and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= {TAG_W{1'b0}};
      rr_r    <= {TAG_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      rr_r    <= rr_s;
      cnt_r   <= cnt_s;
    end
  end

  assign grant_id = grant_r;
  assign busy     = (state_r == LOCKED);

  arbiter_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .push_data (grant_r),
    .pop       (pop_s),
    .head      (tag_head_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

  fixed_activation_arbiter_checker u_checker (
    .clk           (clk),
    .rst           (rst),
    .act_out_valid (act_out_valid),
    .tag_empty     (tag_empty_s)
  );

`ifdef FIXED_ACTIVATION_ARBITER_PERF_EN
  // Saturating counts of locked cycles and of owner-valid cycles that moved no beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles  <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if ((state_r == LOCKED) && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if ((state_r == LOCKED) && req_valid[grant_r] && !accept_s &&
          (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fixed_activation_arbiter.sv
// Randomised scoreboard bench for fixed_activation_arbiter with a behavioural
// shared-unit model (ReLU, configurable latency) and a burst-level reference.
module tb_fixed_activation_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int PAR = 1;
  localparam int BW  = PAR * DW;
  localparam int TBB = 3;
  localparam int TD  = 2;
  localparam int GW  = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*BW-1:0]  req_data;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [BW-1:0]     act_in_data;
  logic              act_in_valid;
  logic              act_in_ready;
  logic [BW-1:0]     act_out_data;
  logic              act_out_valid;
  logic              act_out_ready;
  logic [BW-1:0]     resp_data;
  logic [NR-1:0]     resp_valid;
  logic [NR-1:0]     resp_ready;
  logic [GW-1:0]     grant_id;
  logic              busy;

  fixed_activation_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .PARALLELISM(PAR), .TENSOR_BEATS(TBB), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .act_in_data(act_in_data), .act_in_valid(act_in_valid), .act_in_ready(act_in_ready),
    .act_out_data(act_out_data), .act_out_valid(act_out_valid), .act_out_ready(act_out_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int req; logic [BW-1:0] data; } beat_t;
  typedef struct { logic [BW-1:0] data; int ready_at; } unit_t;

  beat_t sb_q[$];
  unit_t unit_q[$];
  int    dut_grants[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    n_acc   = 0;
  bit    prev_busy = 1'b0;

  int lat = 1, p_valid = 100, p_in_ready = 100, p_resp_ready = 100;
  logic [NR-1:0] vmask = '0;

  bit m_busy = 1'b0;
  int m_owner = 0, m_rr = 0, m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] act_fn(input logic [BW-1:0] x);
    logic [BW-1:0] y;
    y = x;
    for (int e = 0; e < PAR; e++)
      if (x[e*DW+DW-1]) y[e*DW +: DW] = '0;
    return y;
  endfunction

  function automatic int first_from(input logic [NR-1:0] v, input int start);
    for (int k = 0; k < NR; k++)
      if (v[(start + k) % NR]) return (start + k) % NR;
    return start;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_rr = 0; m_cnt = 0; prev_busy = 1'b0;
    sb_q.delete(); unit_q.delete();
  endtask

  // One clock: drive at negedge, check and advance the reference 3 time units later.
  task automatic cycle();
    logic [NR-1:0] exp_ready;
    logic          exp_in_valid, exp_out_ready, out_drv, full;
    logic [BW-1:0] beat;
    @(negedge clk);
    cyc++;
    for (int r = 0; r < NR; r++) begin
      req_valid[r]         = vmask[r] && ($urandom_range(99) < p_valid);
      req_data[r*BW +: BW] = BW'($urandom);
      resp_ready[r]        = ($urandom_range(99) < p_resp_ready);
    end
    act_in_ready  = ($urandom_range(99) < p_in_ready);
    out_drv       = (unit_q.size() > 0) && (unit_q[0].ready_at <= cyc);
    act_out_valid = out_drv;
    act_out_data  = out_drv ? act_fn(unit_q[0].data) : BW'($urandom);
    #3;
    full          = (sb_q.size() >= TD);
    exp_in_valid  = m_busy && req_valid[m_owner] && !full;
    exp_ready     = '0;
    if (m_busy && act_in_ready && !full) exp_ready[m_owner] = 1'b1;
    exp_out_ready = (sb_q.size() > 0) && resp_ready[sb_q[0].req];
    check("busy", busy, m_busy);
    if (m_busy) check("grant_id", grant_id, m_owner);
    check("req_ready", req_ready, exp_ready);
    check("act_in_valid", act_in_valid, exp_in_valid);
    if (exp_in_valid) check("act_in_data", act_in_data, req_data[m_owner*BW +: BW]);
    check("act_out_ready", act_out_ready, exp_out_ready);
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
    prev_busy = busy;
    n_acc += $countones(req_valid & req_ready);
    if (out_drv && exp_out_ready) void'(unit_q.pop_front());
    if (exp_in_valid && act_in_ready) begin
      beat = req_data[m_owner*BW +: BW];
      unit_q.push_back('{data: beat, ready_at: cyc + lat});
      sb_q.push_back('{req: m_owner, data: act_fn(beat)});
      m_cnt++;
      if (m_cnt == TBB) begin
        m_cnt = 0; m_rr = (m_owner + 1) % NR; m_busy = 1'b0;
      end
    end else if (!m_busy && (|req_valid)) begin
      m_owner = first_from(req_valid, m_rr);
      m_busy  = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_grant_id"}, grant_id, '0);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_act_in_valid"}, act_in_valid, 1'b0);
    check({tag, "_act_out_ready"}, act_out_ready, 1'b0);
    check({tag, "_resp_valid"}, resp_valid, '0);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    logic [NR-1:0] exp_rv;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        exp_rv = '0;
        if (act_out_valid && sb_q.size() > 0) exp_rv[sb_q[0].req] = 1'b1;
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv != '0) begin
          check("resp_data", resp_data, sb_q[0].data);
          if (resp_ready[sb_q[0].req]) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_b[5];
    bit found;
    exp_b = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = '0;
    act_in_ready = 1'b0; act_out_valid = 1'b0; act_out_data = '0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single requester 2, everything ready: back-to-back bursts with one idle cycle.
    vmask = 4'b0100; dut_grants.delete();
    run(40);
    check("single_grant_count", dut_grants.size(), 10);
    foreach (dut_grants[i]) check("single_grant_id", dut_grants[i], 2);
    vmask = '0; run(6);

    // Results blocked with a slow unit: tag FIFO caps outstanding beats.
    lat = 3; vmask = '1; p_resp_ready = 0; n_acc = 0;
    run(15);
    check("blocked_accepts", n_acc, TD);
    p_resp_ready = 100;
    run(30);

    // Fully random traffic.
    lat = 2; p_valid = 60; p_in_ready = 70; p_resp_ready = 70;
    run(3000);

    // Reset in the middle of a burst.
    lat = 1; p_valid = 100; p_in_ready = 100; p_resp_ready = 100; vmask = '1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      found = m_busy && (m_cnt == 1);
    end
    check("midburst_reached", found, 1'b1);
    #2;
    rst = 1'b1; act_out_valid = 1'b0;
    #1;
    check_reset_outputs("midburst");
    model_reset();
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // All requesters valid after reset: strict 0,1,2,3,0 rotation.
    dut_grants.delete();
    run(20);
    check("rr_grant_count", dut_grants.size(), 5);
    foreach (dut_grants[i]) if (i < 5) check("rr_grant_order", dut_grants[i], exp_b[i]);

    lat = 3; p_valid = 50; p_in_ready = 60; p_resp_ready = 50;
    run(2000);

    vmask = '0; p_resp_ready = 100;
    run(30);
    check("drain_scoreboard", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_activation_arbiter.md
Name: fixed_activation_arbiter

Overview:
- Shares one fixed-point activation datapath instance (hardshrink/relu/etc.) between NUM_REQ independent upstream streams.
- Grants whole tensors (bursts of beats) round-robin, forwards the granted stream to the shared unit, and routes results back to the owning requester.
- Routing uses an in-order tag FIFO, which tolerates pipelined datapaths.
- Sits between layer schedulers and the activation_layers RTL.

Parameters:
- NUM_REQ, 4, number of requester streams (>=2)
- DATA_WIDTH, 8, element width (DATA_IN_0_PRECISION_0 of shared unit)
- PARALLELISM, 1, elements per beat (PARALLELISM_DIM_0*DIM_1)
- TENSOR_BEATS, 10, beats per tensor burst (TENSOR_SIZE/PARALLELISM, >=1)
- TAG_DEPTH, 4, max beats in flight inside shared unit (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_data  in  NUM_REQ*PARALLELISM*DATA_WIDTH  flattened requester data, requester r at slice r
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready
- act_in_data  out  PARALLELISM*DATA_WIDTH  to shared unit data_in_0
- act_in_valid  out  1  to shared unit
- act_in_ready  in  1  from shared unit
- act_out_data  in  PARALLELISM*DATA_WIDTH  from shared unit data_out_0
- act_out_valid  in  1  from shared unit
- act_out_ready  out  1  to shared unit
- resp_data  out  PARALLELISM*DATA_WIDTH  broadcast result data
- resp_valid  out  NUM_REQ  one-hot result valid
- resp_ready  in  NUM_REQ  per-requester result ready
- grant_id  out  $clog2(NUM_REQ)  current owner, valid when busy
- busy  out  1  high in LOCKED

Behaviour:
- Reset values: state IDLE, rr pointer 0, beat counter 0, tag FIFO empty, busy=0, grant_id=0, all req_ready=0, act_in_valid=0, act_out_ready=0, resp_valid=0.
- FSM, two states:
  - IDLE: if any req_valid, pick first requester at or after rr pointer (wrapping), register grant_id, go to LOCKED. Always one bubble cycle per burst.
  - LOCKED: act_in_data = req_data[grant_id]; act_in_valid = req_valid[grant_id] && !tag_full; req_ready[grant_id] = act_in_ready && !tag_full; other req_ready = 0.
- Beat accept = act_in_valid && act_in_ready.
  - On accept: push grant_id into tag FIFO and increment beat counter.
  - On the accept where counter == TENSOR_BEATS-1: counter <- 0, rr pointer <- grant_id+1 mod NUM_REQ, state <- IDLE.
- Grant is held for the full burst even if the owner deasserts valid mid-burst. No preemption.
- Return path is combinational from tag FIFO head h:
  - resp_valid = onehot(h) when act_out_valid && !tag_empty.
  - act_out_ready = resp_ready[h] && !tag_empty.
  - resp_data = act_out_data.
  - Pop on act_out_valid && act_out_ready.
- Tag FIFO full blocks push even if a pop occurs the same cycle. Simultaneous push and pop when not full or empty keeps occupancy unchanged.
- act_out_valid while tag FIFO empty is a protocol error: simulation assertion; output stays blocked.
- Latency through the arbiter: 0 cycles on the data path. Grant takes 1 cycle from IDLE.
- Reset mid-burst:
  - All state is cleared asynchronously and tags are dropped.
  - Shared unit must share rst. Partial tensors are lost; requesters restart.
- Single requester active continuously: receives every burst, each separated by one IDLE cycle.

Optional Feature:
- FIXED_ACTIVATION_ARBITER_PERF_EN
- Defined: adds outputs perf_busy_cycles (32b, counts LOCKED cycles) and perf_stall_cycles (32b, counts LOCKED cycles where req_valid[grant_id] && !(accept)). Both saturate at max and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fixed_activation_arbiter_pkg:
  - state enum {IDLE, LOCKED}
  - helper function for round-robin next-index search
  - TAG_W = $clog2(NUM_REQ) computation convention
- Sub-module arbiter_tag_fifo: synchronous FIFO, width TAG_W, depth TAG_DEPTH, full/empty flags, async active-high rst.

Test Plan:
- Single requester 2, TENSOR_BEATS=3, identity unit -> grant_id=2, 3 beats returned on resp_valid=4'b0100, busy drops after 3rd accept.
- All 4 requesters valid from reset, TENSOR_BEATS=2 -> bursts granted in order 0,1,2,3,0 with one IDLE cycle between bursts.
- Shared unit with 3-cycle latency, TAG_DEPTH=2, resp_ready held 0 -> at most 2 beats accepted, then req_ready=0. After resp_ready=1, remaining beats flow.
- Owner drops req_valid for 5 cycles mid-burst while requester 1 valid -> grant stays with owner, no beats from requester 1 until owner completes TENSOR_BEATS.
- Assert rst during beat 2 of 4 -> all outputs return to reset values immediately. Next burst starts at requester 0 with counter 0.
- PERF_EN defined, owner valid with act_in_ready low 7 cycles -> perf_stall_cycles=7.
